// File: rtl/weight_bias_loader.sv
// Run-time convolution kernel loader: assembles NW weights plus one bias from a
// valid/ready stream in a shadow bank and commits the full set atomically.
//   state | meaning
//   IDLE  | no load in progress, stream not accepted
//   LOAD  | accepting words into the shadow bank
module weight_bias_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load_start,
    input  logic [DATA_WIDTH-1:0]                       s_data,
    input  logic                                        s_valid,
    input  logic                                        s_last,
    output logic                                        s_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weights,
    output logic [DATA_WIDTH-1:0]                       bias,
    output logic                                        params_valid,
    output logic                                        busy,
    output logic                                        load_err
);
    localparam int NW = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW = $clog2(NW + 1);
    localparam logic [CW-1:0] CNT_BIAS = CW'(NW);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shadow [NW];

    // A restart pulse takes priority over any word offered in the same cycle.
    assign s_ready = (state == LOAD) && !load_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            weights      <= '0;
            bias         <= '0;
            params_valid <= 1'b0;
            busy         <= 1'b0;
            load_err     <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                shadow[i] <= '0;
            end
        end else if (load_start) begin
            state    <= LOAD;
            cnt      <= '0;
            busy     <= 1'b1;
            load_err <= 1'b0;
        end else if (state == LOAD && s_valid) begin
            for (int i = 0; i < NW; i++) begin
                if (cnt == CW'(i)) begin
                    shadow[i] <= s_data;
                end
            end
            if (cnt == CNT_BIAS) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (s_last) begin
                    // Word 0 lands in the MSBs, matching the constant parameter source.
                    for (int k = 0; k < NW; k++) begin
                        weights[DATA_WIDTH*(NW-k)-1 -: DATA_WIDTH] <= shadow[k];
                    end
                    bias         <= s_data;
                    params_valid <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (s_last) begin
                state    <= IDLE;
                busy     <= 1'b0;
                load_err <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_weight_bias_loader.sv
// Directed bench for weight_bias_loader: table-driven load attempts plus
// hand-written restart, reset and latency sequences.
module tb_weight_bias_loader;
    localparam int DW = 16;
    localparam int NW = 9;

    logic            clk = 1'b0;
    logic            rst, load_start, s_valid, s_last, s_ready;
    logic [DW-1:0]   s_data, bias;
    logic [DW*NW-1:0] weights;
    logic            params_valid, busy, load_err;

    int nvec = 0;
    int nmis = 0;

    logic [DW*NW-1:0] exp_w;
    logic [DW-1:0]    exp_b;
    logic             exp_pv;

    typedef struct {
        logic [DW-1:0] base;
        int            nwords;
        int            last_at;   // -1: s_last never asserted
        bit            gaps;
        bit            exp_err;
        bit            exp_commit;
    } vec_t;

    vec_t vecs [4];

    weight_bias_loader #(.DATA_WIDTH(DW), .KERNEL_SIZE(3)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .s_data(s_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .weights(weights), .bias(bias), .params_valid(params_valid),
        .busy(busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*NW-1:0] pack_set(input logic [DW-1:0] base);
        logic [DW*NW-1:0] w;
        w = '0;
        for (int k = 0; k < NW; k++) w[DW*(NW-k)-1 -: DW] = base + DW'(k);
        return w;
    endfunction

    task automatic chk(input string name, input logic [DW*NW-1:0] act, input logic [DW*NW-1:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic chk_idle(input string tag, input bit err);
        chk({tag, " busy"}, {{(DW*NW-1){1'b0}}, busy}, '0);
        chk({tag, " s_ready"}, {{(DW*NW-1){1'b0}}, s_ready}, '0);
        chk({tag, " load_err"}, {{(DW*NW-1){1'b0}}, load_err}, {{(DW*NW-1){1'b0}}, err});
        chk({tag, " params_valid"}, {{(DW*NW-1){1'b0}}, params_valid}, {{(DW*NW-1){1'b0}}, exp_pv});
        chk({tag, " weights"}, weights, exp_w);
        chk({tag, " bias"}, {{(DW*NW-DW){1'b0}}, bias}, {{(DW*NW-DW){1'b0}}, exp_b});
    endtask

    // Called just after a negedge; returns after the negedge following acceptance.
    task automatic send_word(input logic [DW-1:0] d, input bit last, output int cycles);
        bit acc;
        s_data = d; s_last = last; s_valid = 1'b1;
        cycles = 0;
        acc = 1'b0;
        while (!acc && cycles < 50) begin
            #1 acc = s_ready;
            @(negedge clk);
            cycles++;
        end
        if (!acc) begin
            nvec++; nmis++;
            $display("FAIL send_word timeout: got s_ready=0, want 1 within 50 cycles");
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_set(input logic [DW-1:0] base, input int n, input int last_at,
                            input bit gaps, output int total);
        int c;
        total = 0;
        for (int i = 0; i < n; i++) begin
            send_word(base + DW'(i), (i == last_at), c);
            total += c;
            if (gaps) begin
                s_valid = 1'b0;
                repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        int tot;
        rst = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        exp_w = '0; exp_b = '0; exp_pv = 1'b0;

        vecs[0] = '{base: 16'h0001, nwords: 10, last_at: 9,  gaps: 1'b1, exp_err: 1'b0, exp_commit: 1'b1};
        vecs[1] = '{base: 16'h0001, nwords: 5,  last_at: 4,  gaps: 1'b0, exp_err: 1'b1, exp_commit: 1'b0};
        vecs[2] = '{base: 16'hF000, nwords: 10, last_at: -1, gaps: 1'b0, exp_err: 1'b1, exp_commit: 1'b0};
        vecs[3] = '{base: 16'h0200, nwords: 10, last_at: 9,  gaps: 1'b1, exp_err: 1'b0, exp_commit: 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset", 1'b0);

        // Full-rate basic load: busy from the cycle after load_start, 10 transfer cycles.
        pulse_start();
        chk("basic busy", {{(DW*NW-1){1'b0}}, busy}, {{(DW*NW-1){1'b0}}, 1'b1});
        send_set(16'h0001, 10, 9, 1'b0, tot);
        chk("basic cycles", DW*NW'(tot), DW*NW'(10));
        exp_w = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                 16'h0006, 16'h0007, 16'h0008, 16'h0009};
        exp_b = 16'h000A; exp_pv = 1'b1;
        chk_idle("basic", 1'b0);

        for (int v = 0; v < 4; v++) begin
            pulse_start();
            send_set(vecs[v].base, vecs[v].nwords, vecs[v].last_at, vecs[v].gaps, tot);
            if (vecs[v].exp_commit) begin
                exp_w = pack_set(vecs[v].base);
                exp_b = vecs[v].base + DW'(NW);
                exp_pv = 1'b1;
            end
            chk_idle($sformatf("vec%0d", v), vecs[v].exp_err);
        end

        // Restart with s_valid high: no transfer, error cleared, fresh set commits.
        pulse_start();
        send_set(16'hAAAA, 4, -1, 1'b0, tot);
        load_start = 1'b1; s_valid = 1'b1; s_data = 16'hAAAA;
        #1 chk("restart s_ready", {{(DW*NW-1){1'b0}}, s_ready}, '0);
        @(negedge clk);
        load_start = 1'b0; s_valid = 1'b0;
        chk("restart load_err", {{(DW*NW-1){1'b0}}, load_err}, '0);
        chk("restart busy", {{(DW*NW-1){1'b0}}, busy}, {{(DW*NW-1){1'b0}}, 1'b1});
        send_set(16'h1110, 10, 9, 1'b0, tot);
        exp_w = pack_set(16'h1110); exp_b = 16'h1119;
        chk_idle("restart", 1'b0);

        // Reset mid-load wipes committed outputs too.
        pulse_start();
        send_set(16'h3330, 6, -1, 1'b0, tot);
        rst = 1'b1; load_start = 1'b1;
        @(negedge clk);
        rst = 1'b0; load_start = 1'b0;
        exp_w = '0; exp_b = '0; exp_pv = 1'b0;
        chk_idle("midreset", 1'b0);
        pulse_start();
        send_set(16'h0500, 10, 9, 1'b0, tot);
        exp_w = pack_set(16'h0500); exp_b = 16'h0509; exp_pv = 1'b1;
        chk_idle("postreset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/weight_bias_loader.md
# weight_bias_loader

Run-time loader for convolution kernel parameters. It accepts a word stream of KERNEL_SIZE*KERNEL_SIZE weights followed by one bias over a valid/ready handshake. It assembles them in a shadow bank and commits the complete set atomically to a packed weights/bias bus. The bus has the same packing as the fixed-constant parameter source, so a convolution engine can use either interchangeably, with new kernels loaded without resynthesis.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one weight or bias word (signed fixed point, passed through unmodified)
- KERNEL_SIZE, 3, kernel edge; NW = KERNEL_SIZE*KERNEL_SIZE weights per set

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse; begins (or restarts) loading a new set
- s_data  in  DATA_WIDTH  stream word
- s_valid  in  1  s_data valid
- s_last  in  1  marks the final (bias) word of a set
- s_ready  out  1  loader accepts a word this cycle
- weights  out  DATA_WIDTH*NW  committed weights, packed
- bias  out  DATA_WIDTH  committed bias
- params_valid  out  1  a committed set exists
- busy  out  1  load in progress
- load_err  out  1  sticky framing error of the last load attempt

## Operation
- Stream order:
  - Word 0 is weight slot 0, which occupies the MSBs: weights[DATA_WIDTH*NW-1 -: DATA_WIDTH].
  - Word k goes to weights[DATA_WIDTH*(NW-k)-1 -: DATA_WIDTH] for k = 0..NW-1.
  - Word NW is the bias.
- States:
  - IDLE: s_ready=0, busy=0.
  - LOAD: s_ready=1 unless load_start=1 this cycle; busy=1.
- Transitions:
  - load_start in any state: go to LOAD, word counter cnt=0, load_err cleared.
  - A transfer is s_valid && s_ready. In LOAD, each transfer writes the shadow slot cnt and increments cnt (width clog2(NW+1)).
  - Transfer with cnt==NW and s_last=1: commit the shadow bank to the weights/bias outputs, set params_valid=1, go to IDLE.
  - Transfer with s_last=1 and cnt<NW (early last): load_err=1, go to IDLE, no commit.
  - Transfer with cnt==NW and s_last=0 (missing last): load_err=1, go to IDLE, no commit.
- Double buffering: the outputs change only on commit. A failed or in-progress load leaves the previous committed set and params_valid untouched.
- params_valid is cleared only by rst.
- Words offered in IDLE are not accepted (s_ready=0). The stream source must hold them, per the handshake.

## Timing
- Reset values:
  - state=IDLE, cnt=0, shadow bank=0.
  - weights=0, bias=0.
  - params_valid=0, busy=0, load_err=0.
  - s_ready=0.
- s_ready is combinational from state and load_start. All other outputs are registered.
- Full-rate load takes NW+1 consecutive transfer cycles.
- Commit latency: weights, bias and params_valid update on the clock edge that captures the bias transfer. They are visible the cycle after that handshake, and busy falls in the same cycle.
- The first transfer may occur in the cycle after load_start. With s_valid held high, a 3x3 set completes 10 cycles after load_start and is visible on cycle 11.
- s_valid gaps stall cnt. No timeout is applied.
- Simultaneous events:
  - load_start in the same cycle as s_valid in LOAD: no transfer (s_ready low). The restart wins and the partial set is discarded.
  - load_start in the same cycle as rst: rst wins.
- rst mid-load: everything returns to reset values, including the committed outputs and params_valid.

## Test plan
- Basic load, 3x3:
  - Stimulus: load_start, then s_data 0x0001..0x000A back-to-back, s_last on the 10th word.
  - Required: weights = {0x0001,...,0x0009} with 0x0001 in the MSBs, bias=0x000A, params_valid=1 and busy=0 one cycle after the 10th handshake, load_err=0.
- Backpressure and gaps:
  - Stimulus: the same set with s_valid toggling every other cycle and random idle gaps.
  - Required: identical result. cnt advances only on handshakes.
- Early last:
  - Stimulus: after committing the set above, load_start and then 5 words with s_last on the 5th.
  - Required: load_err=1, state IDLE, weights/bias still hold the 0x0001..0x000A set, params_valid=1.
- Missing last:
  - Stimulus: 10 words 0xF000..0xF009 with s_last never asserted.
  - Required: load_err=1 after the 10th word, no commit.
- Restart mid-load:
  - Stimulus: load 4 words 0xAAAA, pulse load_start while s_valid=1, then a full set 0x1110..0x1119.
  - Required: no transfer in the load_start cycle, load_err cleared, committed set is 0x1110..0x1118 with bias 0x1119.
- Reset mid-load:
  - Stimulus: assert rst after 6 words.
  - Required: all outputs 0, params_valid=0, s_ready=0. A subsequent full load then commits normally.
